// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce bank.
package debounce_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StWait = 1'b1
  } deb_state_e;

  localparam int unsigned DEFAULT_HOLD  = 4095;
  localparam int unsigned DEFAULT_CNT_W = 12;

endpackage

// File: rtl/debounce_bank_if.sv
// Per-channel level and pulse bundle between board pins and the debounce bank.
interface debounce_bank_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0] raw;
  logic [N_CH-1:0] clean;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] busy;

  modport master (output raw, input clean, input rise, input fall, input busy);
  modport slave  (input raw, output clean, output rise, output fall, output busy);
endinterface

// File: rtl/debounce_channel.sv
// Single debounce channel: optional 2-flop synchroniser (DEBOUNCE_SYNC_EN), hold FSM, edge pulses.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W      = DEFAULT_CNT_W,
  parameter int unsigned HOLD       = DEFAULT_HOLD,
  parameter logic        INIT_LEVEL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o,
  output logic busy_o
);

  // HOLD == 2^CNT_W still loads as all-ones after truncation.
  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD - 1);

  logic s;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {2{INIT_LEVEL}};
    end else begin
      sync_q <= {sync_q[0], raw_i};
    end
  end

  assign s = sync_q[1];
`else
  assign s = raw_i;
`endif

  deb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             clean_q;
  logic             rise_q;
  logic             fall_q;
  logic             busy_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      clean_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (s != clean_q) begin
            cnt_q   <= HoldLoad;
            state_q <= StWait;
            busy_q  <= 1'b1;
          end
        end
        StWait: begin
          if (s == clean_q) begin
            // Input bounced back: abandon this attempt silently.
            cnt_q   <= '0;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (cnt_q == '0) begin
            clean_q <= s;
            rise_q  <= s;
            fall_q  <= ~s;
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/debounce_bank.sv
// N_CH independent debounce channels; synchroniser enabled by defining DEBOUNCE_SYNC_EN.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned CNT_W      = DEFAULT_CNT_W,
  parameter int unsigned HOLD       = DEFAULT_HOLD,
  parameter logic        INIT_LEVEL = 1'b0
) (
  input logic            clock,
  input logic            reset_n,
  debounce_bank_if.slave deb_io
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W      (CNT_W),
      .HOLD       (HOLD),
      .INIT_LEVEL (INIT_LEVEL)
    ) u_ch (
      .clock   (clock),
      .reset_n (reset_n),
      .raw_i   (deb_io.raw[i]),
      .clean_o (deb_io.clean[i]),
      .rise_o  (deb_io.rise[i]),
      .fall_o  (deb_io.fall[i]),
      .busy_o  (deb_io.busy[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Self-checking bench for debounce_bank: run-length reference model plus directed latency pins.
module tb_debounce_bank;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned HOLD  = 8;
  localparam int unsigned CNT_W = 4;
  localparam logic        INIT_LEVEL = 1'b0;
`ifdef DEBOUNCE_SYNC_EN
  localparam int unsigned SYNC = 2;
`else
  localparam int unsigned SYNC = 0;
`endif
  localparam int unsigned LAT = HOLD + SYNC;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  debounce_bank_if #(.N_CH(N_CH)) bus ();

  debounce_bank #(
    .N_CH       (N_CH),
    .CNT_W      (CNT_W),
    .HOLD       (HOLD),
    .INIT_LEVEL (INIT_LEVEL)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .deb_io  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: clean flips once s has disagreed with it on HOLD+1 consecutive edges.
  logic [N_CH-1:0] m_clean, m_rise, m_fall, m_busy, m_h0, m_h1;
  int unsigned     m_run [N_CH];

  task automatic model_reset();
    m_clean = {N_CH{INIT_LEVEL}};
    m_h0    = {N_CH{INIT_LEVEL}};
    m_h1    = {N_CH{INIT_LEVEL}};
    m_rise  = '0;
    m_fall  = '0;
    m_busy  = '0;
    for (int i = 0; i < N_CH; i++) m_run[i] = 0;
  endtask

  task automatic model_edge(input logic [N_CH-1:0] r);
    logic [N_CH-1:0] s;
    s = (SYNC == 2) ? m_h1 : r;
    m_h1 = m_h0;
    m_h0 = r;
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (s[i] != m_clean[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == HOLD + 1) begin
          m_clean[i] = s[i];
          m_rise[i]  = s[i];
          m_fall[i]  = ~s[i];
          m_run[i]   = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_busy[i] = (m_run[i] != 0);
    end
  endtask

  task automatic check_vec(input string name, input logic [N_CH-1:0] act,
                           input logic [N_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check_vec("clean", bus.clean, m_clean);
    check_vec("rise", bus.rise, m_rise);
    check_vec("fall", bus.fall, m_fall);
    check_vec("busy", bus.busy, m_busy);
    check_vec("rise_fall_excl", bus.rise & bus.fall, '0);
  endtask

  // Drive raw mid-cycle, advance one edge, step the model, compare 1 time unit later.
  task automatic cycle(input logic [N_CH-1:0] r);
    bus.raw = r;
    @(posedge clock);
    if (reset_n) model_edge(r);
    else model_reset();
    #1;
    compare_all();
  endtask

  logic [N_CH-1:0] cur;
  int j_busy, j_rise, n_pulse, n_busy, j_fall;

  initial begin
    bus.raw = '0;
    cur     = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    compare_all();
    check_vec("reset_clean", bus.clean, 4'b0000);
    #2 reset_n = 1'b1;

    // Quiet inputs
    for (int j = 0; j < 20; j++) cycle(cur);
    check_vec("quiet_clean", bus.clean, 4'b0000);

    // Channel 0 rises and holds
    cur[0] = 1'b1;
    j_busy = -1;
    j_rise = -1;
    n_pulse = 0;
    for (int j = 0; j < 14; j++) begin
      cycle(cur);
      if (bus.busy[0] && j_busy < 0) j_busy = j;
      if (bus.rise[0]) begin
        n_pulse++;
        if (j_rise < 0) j_rise = j;
      end
    end
    check_int("ch0_busy_start", j_busy, int'(SYNC));
    check_int("ch0_rise_edge", j_rise, int'(LAT));
    check_int("ch0_rise_count", n_pulse, 1);
    check_vec("ch0_after", {bus.clean[0], bus.busy[0]}, 2'b10);

    // Channel 1 short pulse never reaches clean
    n_pulse = 0;
    n_busy = 0;
    for (int j = 0; j < 20; j++) begin
      cur[1] = (j < 6);
      cycle(cur);
      if (bus.rise[1] || bus.fall[1] || bus.clean[1]) n_pulse++;
      if (bus.busy[1]) n_busy++;
    end
    check_int("ch1_no_output", n_pulse, 0);
    check_int("ch1_busy_cycles", n_busy, 6);

    // Channel 2 bounces 1,0,1,0,1 then holds 1
    j_rise = -1;
    n_pulse = 0;
    for (int k = 0; k < 20; k++) begin
      cur[2] = (k >= 4) ? 1'b1 : ((k % 2) == 0);
      cycle(cur);
      if (bus.rise[2]) begin
        n_pulse++;
        if (j_rise < 0) j_rise = k - 4;
      end
    end
    check_int("ch2_rise_edge", j_rise, int'(LAT));
    check_int("ch2_rise_count", n_pulse, 1);

    // All channels high, then all fall together
    cur = 4'b1111;
    for (int j = 0; j < int'(LAT) + 4; j++) cycle(cur);
    check_vec("all_high", bus.clean, 4'b1111);
    cur = 4'b0000;
    j_fall = -1;
    for (int j = 0; j < 14; j++) begin
      cycle(cur);
      if (bus.fall == 4'b1111 && j_fall < 0) j_fall = j;
    end
    check_int("all_fall_edge", j_fall, int'(LAT));
    check_vec("all_low", bus.clean, 4'b0000);

    // Reset in the middle of a hold on channel 3
    cur = 4'b1000;
    for (int j = 0; j < int'(SYNC) + 3; j++) cycle(cur);
    check_vec("ch3_waiting", bus.busy, 4'b1000);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_vec("ch3_reset", {bus.clean[3], bus.busy[3], bus.rise[3], bus.fall[3]},
              {INIT_LEVEL, 3'b000});
    cur = '0;
    cycle(cur);
    cycle(cur);
    #2 reset_n = 1'b1;

    // Randomised traffic alternating calm and bouncy phases
    for (int j = 0; j < 4000; j++) begin
      int unsigned odds;
      odds = ((j / 250) % 2 == 0) ? 14 : 3;
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(odds - 1) == 0) cur[i] = ~cur[i];
      end
      if (j == 2600) begin
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        cycle(cur);
        #2 reset_n = 1'b1;
      end
      cycle(cur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
